// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared LETC core types: opcodes, formats, decoded instruction,
//            immediate assembly and the table of supported opcodes.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

    typedef logic [4:0] reg_index_t;

    typedef enum logic [4:0] {
        OPCODE_LOAD     = 5'b00000,
        OPCODE_MISC_MEM = 5'b00011,
        OPCODE_OP_IMM   = 5'b00100,
        OPCODE_AUIPC    = 5'b00101,
        OPCODE_STORE    = 5'b01000,
        OPCODE_OP       = 5'b01100,
        OPCODE_LUI      = 5'b01101,
        OPCODE_BRANCH   = 5'b11000,
        OPCODE_JALR     = 5'b11001,
        OPCODE_JAL      = 5'b11011,
        OPCODE_SYSTEM   = 5'b11100
    } opcode_e;

    typedef enum logic [2:0] {
        INSTR_FORMAT_R    = 3'd0,
        INSTR_FORMAT_I    = 3'd1,
        INSTR_FORMAT_S    = 3'd2,
        INSTR_FORMAT_B    = 3'd3,
        INSTR_FORMAT_U    = 3'd4,
        INSTR_FORMAT_J    = 3'd5,
        INSTR_FORMAT_UIMM = 3'd6
    } instr_format_e;

    typedef enum logic [1:0] {
        RD_FROM_ALU_RESULT  = 2'd0,
        RD_FROM_MEM_LOAD    = 2'd1,
        RD_FROM_NEXT_SEQ_PC = 2'd2,
        RD_FROM_CSR         = 2'd3
    } rd_src_e;

    // Bit n set when opcode n (instr[6:2]) is implemented.
    localparam logic [31:0] OPCODE_LEGAL_MASK = 32'h1B00_3139;

    typedef struct packed {
        logic [31:0]   pc;
        opcode_e       opcode;
        instr_format_e format;
        reg_index_t    rs1;
        reg_index_t    rs2;
        reg_index_t    rd;
        logic [2:0]    funct3;
        logic [6:0]    funct7;
        logic [31:0]   imm;
        rd_src_e       rd_src;
        logic          rd_we;
        logic          illegal;
    } decoded_instr_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input instr_format_e format);
        logic [31:0] imm;
        imm = '0;
        case (format)
            INSTR_FORMAT_I:    imm = {{20{instr[31]}}, instr[31:20]};
            INSTR_FORMAT_S:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            INSTR_FORMAT_B:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            INSTR_FORMAT_U:    imm = {instr[31:12], 12'b0};
            INSTR_FORMAT_J:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            INSTR_FORMAT_UIMM: imm = {27'b0, instr[19:15]};
            default:           imm = '0;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_s2_decode_logic.sv
`default_nettype none
// ============================================================================
// Module   : core_s2_decode_logic
// Brief    : Combinational RV32I field split, immediate, rd source/enable and
//            illegal-encoding detection.
// Revision : 1.0 - initial release
// ============================================================================
module core_s2_decode_logic
    import core_pkg::*;
(
    input  logic [31:0]    i_instr,
    input  logic [31:0]    i_pc,
    output decoded_instr_t o_decoded
);

    opcode_e       w_opcode;
    instr_format_e w_format;
    rd_src_e       w_rd_src;
    logic [2:0]    w_funct3;
    reg_index_t    w_rd;
    logic          w_legal;
    logic          w_writes_rd;

    always_comb begin
        w_opcode = opcode_e'(i_instr[6:2]);
        w_funct3 = i_instr[14:12];
        w_rd     = i_instr[11:7];
        w_legal  = (i_instr[1:0] == 2'b11) && OPCODE_LEGAL_MASK[i_instr[6:2]];

        w_format = INSTR_FORMAT_R;
        if (w_legal) begin
            case (w_opcode)
                OPCODE_OP:                  w_format = INSTR_FORMAT_R;
                OPCODE_LOAD, OPCODE_OP_IMM,
                OPCODE_JALR, OPCODE_MISC_MEM: w_format = INSTR_FORMAT_I;
                OPCODE_SYSTEM:              w_format = w_funct3[2] ? INSTR_FORMAT_UIMM : INSTR_FORMAT_I;
                OPCODE_STORE:               w_format = INSTR_FORMAT_S;
                OPCODE_BRANCH:              w_format = INSTR_FORMAT_B;
                OPCODE_LUI, OPCODE_AUIPC:   w_format = INSTR_FORMAT_U;
                OPCODE_JAL:                 w_format = INSTR_FORMAT_J;
                default:                    w_format = INSTR_FORMAT_R;
            endcase
        end

        w_rd_src = RD_FROM_ALU_RESULT;
        case (w_opcode)
            OPCODE_LOAD:             w_rd_src = RD_FROM_MEM_LOAD;
            OPCODE_JAL, OPCODE_JALR: w_rd_src = RD_FROM_NEXT_SEQ_PC;
            OPCODE_SYSTEM:           w_rd_src = (w_funct3 != 3'd0) ? RD_FROM_CSR : RD_FROM_ALU_RESULT;
            default:                 w_rd_src = RD_FROM_ALU_RESULT;
        endcase

        w_writes_rd = 1'b0;
        case (w_opcode)
            OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_AUIPC, OPCODE_OP,
            OPCODE_LUI, OPCODE_JAL, OPCODE_JALR: w_writes_rd = 1'b1;
            OPCODE_SYSTEM:                       w_writes_rd = (w_funct3 != 3'd0);
            default:                             w_writes_rd = 1'b0;
        endcase
    end

    always_comb begin
        o_decoded         = '0;
        o_decoded.pc      = i_pc;
        o_decoded.opcode  = w_opcode;
        o_decoded.format  = w_format;
        o_decoded.rs1     = i_instr[19:15];
        o_decoded.rs2     = i_instr[24:20];
        o_decoded.rd      = w_rd;
        o_decoded.funct3  = w_funct3;
        o_decoded.funct7  = i_instr[31:25];
        o_decoded.imm     = imm_gen(i_instr, w_format);
        o_decoded.rd_src  = w_rd_src;
        // Writes to x0 are discarded here so execute never needs to check rd.
        o_decoded.rd_we   = w_legal && w_writes_rd && (w_rd != 5'd0);
        o_decoded.illegal = !w_legal;
    end

endmodule
`default_nettype wire

// File: rtl/core_s2_decode.sv
`default_nettype none
// ============================================================================
// Module   : core_s2_decode
// Brief    : LETC decode stage: registered output slot with valid/ready
//            handshake. Define LETC_DECODE_SKID_EN for a skid entry and a
//            registered fetch-side ready.
// Revision : 1.0 - initial release
// ============================================================================
module core_s2_decode
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_f_valid,
    output logic          o_f_ready,
    input  logic [31:0]   i_f_instr,
    input  logic [31:0]   i_f_pc,
    output logic          o_e_valid,
    input  logic          i_e_ready,
    output logic [31:0]   o_pc,
    output opcode_e       o_opcode,
    output instr_format_e o_format,
    output reg_index_t    o_rs1,
    output reg_index_t    o_rs2,
    output reg_index_t    o_rd,
    output logic [2:0]    o_funct3,
    output logic [6:0]    o_funct7,
    output logic [31:0]   o_imm,
    output rd_src_e       o_rd_src,
    output logic          o_rd_we,
    output logic          o_illegal
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
`ifdef LETC_DECODE_SKID_EN
    localparam logic [1:0] S_SKID  = 2'd2;
`endif

    logic [1:0]     r_state;
    logic [1:0]     w_state_next;
    logic           w_f_ready;
    logic           w_e_valid;
    logic           w_accept;
    logic           w_drain;
    logic           w_slot_load;
    decoded_instr_t w_decoded;
    decoded_instr_t r_slot;
`ifdef LETC_DECODE_SKID_EN
    logic           w_skid_load;
    logic           w_slot_from_skid;
    decoded_instr_t r_skid;
`endif

    core_s2_decode_logic u_decode_logic (
        .i_instr   (i_f_instr),
        .i_pc      (i_f_pc),
        .o_decoded (w_decoded)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) w_state_next = S_FULL;
`ifdef LETC_DECODE_SKID_EN
                S_FULL: begin
                    if (w_accept && !w_drain)      w_state_next = S_SKID;
                    else if (!w_accept && w_drain) w_state_next = S_EMPTY;
                end
                S_SKID:  if (w_drain) w_state_next = S_FULL;
`else
                S_FULL:  if (!w_accept && w_drain) w_state_next = S_EMPTY;
`endif
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_e_valid = (r_state != S_EMPTY);
`ifdef LETC_DECODE_SKID_EN
        // Ready depends only on state, so no path from i_e_ready reaches fetch.
        w_f_ready = !i_flush && (r_state != S_SKID);
`else
        w_f_ready = !i_flush && (!w_e_valid || i_e_ready);
`endif
        w_accept  = i_f_valid && w_f_ready;
        w_drain   = w_e_valid && i_e_ready;
`ifdef LETC_DECODE_SKID_EN
        w_slot_load      = w_accept && ((r_state == S_EMPTY) || w_drain);
        w_skid_load      = w_accept && (r_state == S_FULL) && !w_drain;
        w_slot_from_skid = !i_flush && (r_state == S_SKID) && w_drain;
`else
        w_slot_load      = w_accept;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot        <= '0;
            r_slot.pc     <= RESET_PC;
            r_slot.format <= INSTR_FORMAT_R;
            r_slot.rd_src <= RD_FROM_NEXT_SEQ_PC;
        end else if (w_slot_load) begin
            r_slot <= w_decoded;
`ifdef LETC_DECODE_SKID_EN
        end else if (w_slot_from_skid) begin
            r_slot <= r_skid;
`endif
        end
    end

`ifdef LETC_DECODE_SKID_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skid <= '0;
        end else if (w_skid_load) begin
            r_skid <= w_decoded;
        end
    end
`endif

    assign o_f_ready = w_f_ready;
    assign o_e_valid = w_e_valid;
    assign o_pc      = r_slot.pc;
    assign o_opcode  = r_slot.opcode;
    assign o_format  = r_slot.format;
    assign o_rs1     = r_slot.rs1;
    assign o_rs2     = r_slot.rs2;
    assign o_rd      = r_slot.rd;
    assign o_funct3  = r_slot.funct3;
    assign o_funct7  = r_slot.funct7;
    assign o_imm     = r_slot.imm;
    assign o_rd_src  = r_slot.rd_src;
    assign o_rd_we   = r_slot.rd_we;
    assign o_illegal = r_slot.illegal;

endmodule
`default_nettype wire

// File: tb/tb_core_s2_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_s2_decode
// Brief    : Scoreboard bench for core_s2_decode (base or skid build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_s2_decode;
    import core_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h8000_0000;
`ifdef LETC_DECODE_SKID_EN
    localparam int STALL_CAP = 2;
`else
    localparam int STALL_CAP = 1;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_f_valid = 1'b0;
    logic          o_f_ready;
    logic [31:0]   i_f_instr = '0;
    logic [31:0]   i_f_pc = '0;
    logic          o_e_valid;
    logic          i_e_ready = 1'b0;
    logic [31:0]   o_pc;
    opcode_e       o_opcode;
    instr_format_e o_format;
    reg_index_t    o_rs1, o_rs2, o_rd;
    logic [2:0]    o_funct3;
    logic [6:0]    o_funct7;
    logic [31:0]   o_imm;
    rd_src_e       o_rd_src;
    logic          o_rd_we;
    logic          o_illegal;

    core_s2_decode #(.RESET_PC(TB_RESET_PC)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_f_valid(i_f_valid), .o_f_ready(o_f_ready), .i_f_instr(i_f_instr), .i_f_pc(i_f_pc),
        .o_e_valid(o_e_valid), .i_e_ready(i_e_ready), .o_pc(o_pc), .o_opcode(o_opcode),
        .o_format(o_format), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
        .o_funct3(o_funct3), .o_funct7(o_funct7), .o_imm(o_imm), .o_rd_src(o_rd_src),
        .o_rd_we(o_rd_we), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        logic [29:0] fields;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [1:0]  src;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   idx;
    bit   rand_ready_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference decoder written from the instruction-set tables.
    function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
        exp_t       e;
        logic [4:0] op;
        logic [2:0] f3;
        op       = instr[6:2];
        f3       = instr[14:12];
        e.pc     = pc;
        e.fields = {op, instr[19:15], instr[24:20], instr[11:7], f3, instr[31:25]};
        e.ill    = !((instr[1:0] == 2'b11) &&
                     (op inside {5'h00, 5'h03, 5'h04, 5'h05, 5'h08, 5'h0C, 5'h0D, 5'h18, 5'h19, 5'h1B, 5'h1C}));
        e.fmt    = INSTR_FORMAT_R;
        if (!e.ill) begin
            case (op)
                5'h00, 5'h03, 5'h04, 5'h19: e.fmt = INSTR_FORMAT_I;
                5'h1C: e.fmt = f3[2] ? INSTR_FORMAT_UIMM : INSTR_FORMAT_I;
                5'h08: e.fmt = INSTR_FORMAT_S;
                5'h18: e.fmt = INSTR_FORMAT_B;
                5'h05, 5'h0D: e.fmt = INSTR_FORMAT_U;
                5'h1B: e.fmt = INSTR_FORMAT_J;
                default: e.fmt = INSTR_FORMAT_R;
            endcase
        end
        case (e.fmt)
            INSTR_FORMAT_I:    e.imm = {{20{instr[31]}}, instr[31:20]};
            INSTR_FORMAT_S:    e.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            INSTR_FORMAT_B:    e.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            INSTR_FORMAT_U:    e.imm = {instr[31:12], 12'h000};
            INSTR_FORMAT_J:    e.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            INSTR_FORMAT_UIMM: e.imm = {27'd0, instr[19:15]};
            default:           e.imm = 32'd0;
        endcase
        if (op == 5'h00)                    e.src = RD_FROM_MEM_LOAD;
        else if (op == 5'h1B || op == 5'h19) e.src = RD_FROM_NEXT_SEQ_PC;
        else if (op == 5'h1C && f3 != 3'd0) e.src = RD_FROM_CSR;
        else                                e.src = RD_FROM_ALU_RESULT;
        e.we = !e.ill && (instr[11:7] != 5'd0) &&
               ((op inside {5'h00, 5'h04, 5'h05, 5'h0C, 5'h0D, 5'h1B, 5'h19}) || (op == 5'h1C && f3 != 3'd0));
        return e;
    endfunction

    // Scoreboard: outputs must match the head entry on every valid cycle.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            q.delete();
        end else begin
            if (o_e_valid) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_valid", {31'd0, o_e_valid}, 32'd0);
                end else begin
                    check("sb_pc", o_pc, q[0].pc);
                    check("sb_fields", {2'b0, o_opcode, o_rs1, o_rs2, o_rd, o_funct3, o_funct7}, {2'b0, q[0].fields});
                    check("sb_format", {29'd0, o_format}, {29'd0, q[0].fmt});
                    check("sb_imm", o_imm, q[0].imm);
                    check("sb_rd_we", {31'd0, o_rd_we}, {31'd0, q[0].we});
                    check("sb_illegal", {31'd0, o_illegal}, {31'd0, q[0].ill});
                    if (!q[0].ill) check("sb_rd_src", {30'd0, o_rd_src}, {30'd0, q[0].src});
                    if (i_e_ready) void'(q.pop_front());
                end
            end
            if (i_flush) q.delete();
            else if (i_f_valid && o_f_ready) q.push_back(ref_decode(i_f_instr, i_f_pc));
        end
    end

    always @(posedge i_clk) begin
        if (rand_ready_en) begin
            #1 i_e_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Presents one word and returns 1 ns after the edge that accepted it.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        bit taken;
        @(posedge i_clk); #1;
        i_f_valid = 1'b1;
        i_f_instr = instr;
        i_f_pc    = pc;
        taken     = 1'b0;
        for (int k = 0; k < 50 && !taken; k++) begin
            @(negedge i_clk);
            taken = o_f_ready;
            if (!taken) begin
                @(posedge i_clk); #1;
            end
        end
        if (!taken) check("send_timeout", {31'd0, o_f_ready}, 32'd1);
        @(posedge i_clk); #1;
        i_f_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] sw[6];
        logic [6:0]  ops[13];
        logic [31:0] r;
        sw  = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213, 32'h0050_0293, 32'h0060_0313};
        ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h6B, 7'h00};

        repeat (2) @(negedge i_clk);
        check("rst_e_valid", {31'd0, o_e_valid}, 32'd0);
        check("rst_pc", o_pc, TB_RESET_PC);
        check("rst_format", {29'd0, o_format}, {29'd0, INSTR_FORMAT_R});
        check("rst_rd_src", {30'd0, o_rd_src}, {30'd0, RD_FROM_NEXT_SEQ_PC});
        check("rst_imm", o_imm, 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_f_ready", {31'd0, o_f_ready}, 32'd1);

        i_e_ready = 1'b1;
        send(32'h00A0_0093, 32'h0000_0100);
        @(negedge i_clk);
        check("addi_valid", {31'd0, o_e_valid}, 32'd1);
        check("addi_format", {29'd0, o_format}, {29'd0, INSTR_FORMAT_I});
        check("addi_imm", o_imm, 32'd10);
        check("addi_rd", {27'd0, o_rd}, 32'd1);
        check("addi_rd_src", {30'd0, o_rd_src}, {30'd0, RD_FROM_ALU_RESULT});
        check("addi_rd_we", {31'd0, o_rd_we}, 32'd1);
        check("addi_illegal", {31'd0, o_illegal}, 32'd0);

        send(32'hFE00_0EE3, 32'h0000_0104);
        @(negedge i_clk);
        check("beq_format", {29'd0, o_format}, {29'd0, INSTR_FORMAT_B});
        check("beq_imm", o_imm, 32'hFFFF_FFFC);
        check("beq_rd_we", {31'd0, o_rd_we}, 32'd0);

        send(32'h3400_2573, 32'h0000_0108);
        @(negedge i_clk);
        check("csr_rd_src", {30'd0, o_rd_src}, {30'd0, RD_FROM_CSR});
        check("csr_rd_we", {31'd0, o_rd_we}, 32'd1);

        send(32'h0000_0013, 32'h0000_010C);
        @(negedge i_clk);
        check("nop_rd_we", {31'd0, o_rd_we}, 32'd0);

        send(32'h0000_0000, 32'h0000_0110);
        @(negedge i_clk);
        check("zero_illegal", {31'd0, o_illegal}, 32'd1);
        check("zero_rd_we", {31'd0, o_rd_we}, 32'd0);
        send(32'h0000_006B, 32'h0000_0114);
        @(negedge i_clk);
        check("rsvd_illegal", {31'd0, o_illegal}, 32'd1);
        check("rsvd_rd_we", {31'd0, o_rd_we}, 32'd0);
        repeat (2) @(posedge i_clk);

        // Stall execute while fetch keeps offering words.
        #1;
        i_e_ready = 1'b0;
        i_f_valid = 1'b1;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            i_f_instr = sw[idx];
            i_f_pc    = 32'h400 + 32'(idx * 4);
            @(negedge i_clk);
            if (c >= STALL_CAP) check("stall_f_ready", {31'd0, o_f_ready}, 32'd0);
            if (o_f_ready) idx++;
            @(posedge i_clk); #1;
        end
        check("stall_accepts", idx, STALL_CAP);
        i_e_ready = 1'b1;
        for (int c = 0; c < 30 && idx < 6; c++) begin
            i_f_instr = sw[idx];
            i_f_pc    = 32'h400 + 32'(idx * 4);
            @(negedge i_clk);
            if (o_f_ready) idx++;
            @(posedge i_clk); #1;
        end
        i_f_valid = 1'b0;
        repeat (4) @(posedge i_clk);

        // Flush while an accept is offered, first with the slot empty.
        #1;
        i_f_valid = 1'b1; i_f_instr = 32'h0000_0013; i_f_pc = 32'h500; i_flush = 1'b1;
        @(negedge i_clk);
        check("flush_f_ready", {31'd0, o_f_ready}, 32'd0);
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_f_valid = 1'b0;
        @(negedge i_clk);
        check("flush_e_valid", {31'd0, o_e_valid}, 32'd0);

        // Flush with an occupied, stalled slot.
        i_e_ready = 1'b0;
        send(32'h0070_0393, 32'h0000_0600);
        i_flush = 1'b1; i_f_valid = 1'b1; i_f_instr = 32'h0000_0013; i_f_pc = 32'h604;
        @(negedge i_clk);
        check("flush_full_f_ready", {31'd0, o_f_ready}, 32'd0);
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_f_valid = 1'b0;
        @(negedge i_clk);
        check("flush_full_e_valid", {31'd0, o_e_valid}, 32'd0);
        i_e_ready = 1'b1;

        // Asynchronous reset with a word held in the slot.
        i_e_ready = 1'b0;
        send(32'h0080_0413, 32'h0000_0700);
        #2 i_rst_n = 1'b0;
        #1;
        check("midrst_e_valid", {31'd0, o_e_valid}, 32'd0);
        check("midrst_pc", o_pc, TB_RESET_PC);
        @(negedge i_clk);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_e_ready = 1'b1;

        rand_ready_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            r = $urandom();
            send({r[31:7], ops[$urandom_range(0, 12)]}, 32'h1000 + 32'(n * 4));
        end
        rand_ready_en = 1'b0;
        @(posedge i_clk); #2;
        i_e_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge i_clk);
        check("sb_leftover", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
